// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and types for the TDM demultiplexor
//   NCH           number of output channels
//   chan_t        channel index
//   MODE_SEL/TDM  channel selection mode encodings
//   DEFAULT_WIDTH default data width
package demux_pkg;

    localparam int NCH           = 4;
    localparam int DEFAULT_WIDTH = 32;

    typedef logic [1:0] chan_t;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_TDM = 1'b1;

endpackage

// File: rtl/demux_chan_reg.sv
// rtl/demux_chan_reg.sv - one-entry channel holding register with valid/ready
//   clk, rst     clock, asynchronous active-high reset
//   load, data   write data into the register (takes priority over consume)
//   ready        consumer accepts the held word this cycle
//   out, valid   held word and its valid flag
module demux_chan_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             ready,
    output logic [WIDTH-1:0] out,
    output logic             valid
);

    // Data is never cleared on consume; only valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            out   <= data;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demultiplexor_tdm.sv
// rtl/demultiplexor_tdm.sv - four-way registered demultiplexor, explicit or TDM slot select
//   Clk, Rst              clock, asynchronous active-high reset
//   In, InValid, InReady  input word stream
//   Sel, Mode, FrameStart channel selection controls
//   OutN, ValidN, ReadyN  per-channel holding register handshake (N = 1..4)
//   Slot                  current TDM slot counter
module demultiplexor_tdm
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] In,
    input  logic             InValid,
    output logic             InReady,
    input  logic [1:0]       Sel,
    input  logic             Mode,
    input  logic             FrameStart,
    output logic [WIDTH-1:0] Out1,
    output logic [WIDTH-1:0] Out2,
    output logic [WIDTH-1:0] Out3,
    output logic [WIDTH-1:0] Out4,
    output logic             Valid1,
    output logic             Valid2,
    output logic             Valid3,
    output logic             Valid4,
    input  logic             Ready1,
    input  logic             Ready2,
    input  logic             Ready3,
    input  logic             Ready4,
    output logic [1:0]       Slot
);

    chan_t            target;
    chan_t            slot_q;
    logic             accept;
    logic [NCH-1:0]   valid_v;
    logic [NCH-1:0]   ready_v;
    logic [NCH-1:0]   load_v;
    logic [WIDTH-1:0] out_a [NCH];

    // FrameStart forces slot 0 in TDM mode; it is ignored in select mode.
    always_comb begin
        target = Sel;
        if (Mode == MODE_TDM) begin
            target = FrameStart ? chan_t'(0) : slot_q;
        end
    end

    assign ready_v = {Ready4, Ready3, Ready2, Ready1};

    // Only the targeted channel can back-pressure the input; a word can land
    // in a full channel on the same edge its current word is consumed.
    assign InReady = !valid_v[target] || ready_v[target];
    assign accept  = InValid && InReady;

    always_comb begin
        load_v = '0;
        if (accept) begin
            load_v[target] = 1'b1;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        demux_chan_reg #(
            .WIDTH (WIDTH)
        ) u_reg (
            .clk   (Clk),
            .rst   (Rst),
            .load  (load_v[c]),
            .data  (In),
            .ready (ready_v[c]),
            .out   (out_a[c]),
            .valid (valid_v[c])
        );
    end

    // Next slot follows the slot actually used, so a mid-frame FrameStart
    // restarts the sequence at 1.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            slot_q <= '0;
        end else if (accept && (Mode == MODE_TDM)) begin
            slot_q <= target + chan_t'(1);
        end
    end

    assign Slot   = slot_q;
    assign Out1   = out_a[0];
    assign Out2   = out_a[1];
    assign Out3   = out_a[2];
    assign Out4   = out_a[3];
    assign Valid1 = valid_v[0];
    assign Valid2 = valid_v[1];
    assign Valid3 = valid_v[2];
    assign Valid4 = valid_v[3];

endmodule

// File: tb/tb_demultiplexor_tdm.sv
// tb/tb_demultiplexor_tdm.sv - self-checking bench for demultiplexor_tdm
module tb_demultiplexor_tdm;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] In;
    logic        InValid;
    wire         InReady;
    logic [1:0]  Sel;
    logic        Mode;
    logic        FrameStart;
    wire  [31:0] Out1, Out2, Out3, Out4;
    wire         Valid1, Valid2, Valid3, Valid4;
    logic [3:0]  rdy;
    wire  [1:0]  Slot;

    wire Ready1 = rdy[0];
    wire Ready2 = rdy[1];
    wire Ready3 = rdy[2];
    wire Ready4 = rdy[3];

    demultiplexor_tdm #(.WIDTH(32)) dut (
        .Clk(Clk), .Rst(Rst), .In(In), .InValid(InValid), .InReady(InReady),
        .Sel(Sel), .Mode(Mode), .FrameStart(FrameStart),
        .Out1(Out1), .Out2(Out2), .Out3(Out3), .Out4(Out4),
        .Valid1(Valid1), .Valid2(Valid2), .Valid3(Valid3), .Valid4(Valid4),
        .Ready1(Ready1), .Ready2(Ready2), .Ready3(Ready3), .Ready4(Ready4),
        .Slot(Slot)
    );

    always #5 Clk = ~Clk;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] dout [4];
    logic        dval [4];
    always_comb begin
        dout[0] = Out1; dout[1] = Out2; dout[2] = Out3; dout[3] = Out4;
        dval[0] = Valid1; dval[1] = Valid2; dval[2] = Valid3; dval[3] = Valid4;
    end

    // Reference model: what each channel holds, whether it is unconsumed,
    // and the slot the next TDM word will use.
    logic [31:0] m_out [4];
    bit          m_val [4];
    int          m_slot;

    task automatic model_clear();
        for (int c = 0; c < 4; c++) begin
            m_out[c] = '0;
            m_val[c] = 0;
        end
        m_slot = 0;
    endtask

    // Applies one cycle of stimulus starting at a falling edge and ending at
    // the next falling edge; returns predicted and observed InReady.
    task automatic step(input logic [31:0] d, input logic v, input logic [1:0] s,
                        input logic m, input logic f,
                        output logic exp_ir, output logic obs_ir);
        int t;
        bit acc;
        In = d; InValid = v; Sel = s; Mode = m; FrameStart = f;
        #1;
        t      = m ? (f ? 0 : m_slot) : int'(s);
        exp_ir = !m_val[t] || rdy[t];
        obs_ir = InReady;
        acc    = v && exp_ir;
        @(posedge Clk);
        for (int c = 0; c < 4; c++) begin
            if (acc && c == t) begin
                m_out[c] = d;
                m_val[c] = 1;
            end else if (m_val[c] && rdy[c]) begin
                m_val[c] = 0;
            end
        end
        if (acc && m) m_slot = (t + 1) % 4;
        @(negedge Clk);
        InValid = 1'b0;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        InValid = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        Rst = 1'b1; InValid = 1'b0; Mode = 1'b0; Sel = 2'd0; FrameStart = 1'b0; rdy = 4'b0000;
        @(negedge Clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (dout[c] !== 32'd0 || dval[c] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_ch%0d: got out=%h valid=%b expected out=0 valid=0", c, dout[c], dval[c]);
            end
        end
        vectors++;
        if (Slot !== 2'd0 || InReady !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_slot_ready: got slot=%0d inready=%b expected slot=0 inready=1", Slot, InReady);
        end
        @(negedge Clk);
        Rst = 1'b0;
        model_clear();
        rdy = 4'b1111;
    endtask

    task automatic test_select();
        logic e, o;
        rdy = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            step(32'(i + 1), 1'b1, 2'(i), 1'b0, 1'b0, e, o);
            vectors++;
            if (o !== 1'b1 || dout[i] !== 32'(i + 1) || dval[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL select_ch%0d: got ir=%b out=%h valid=%b expected ir=1 out=%h valid=1",
                         i, o, dout[i], dval[i], i + 1);
            end
            if (i > 0) begin
                vectors++;
                if (dval[i-1] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL select_pulse_ch%0d: got valid=%b expected 0", i - 1, dval[i-1]);
                end
            end
        end
        step(32'd0, 1'b0, 2'd0, 1'b0, 1'b0, e, o);
        vectors++;
        if (dval[3] !== 1'b0 || Slot !== 2'd0) begin
            miscompares++;
            $display("FAIL select_tail: got valid4=%b slot=%0d expected valid4=0 slot=0", dval[3], Slot);
        end
    endtask

    task automatic test_tdm_wrap();
        logic e, o;
        do_reset();
        rdy = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (Slot !== 2'(i % 4)) begin
                miscompares++;
                $display("FAIL tdm_slot_%0d: got %0d expected %0d", i, Slot, i % 4);
            end
            step(32'(10 + i), 1'b1, 2'd3, 1'b1, (i == 0), e, o);
            vectors++;
            if (dout[i % 4] !== 32'(10 + i) || dval[i % 4] !== 1'b1) begin
                miscompares++;
                $display("FAIL tdm_word_%0d: got out=%h valid=%b expected out=%h valid=1",
                         i, dout[i % 4], dval[i % 4], 10 + i);
            end
        end
        vectors++;
        if (Slot !== 2'd1) begin
            miscompares++;
            $display("FAIL tdm_final_slot: got %0d expected 1", Slot);
        end
    endtask

    task automatic test_backpressure();
        logic e, o;
        do_reset();
        rdy = 4'b1011;
        step(32'hA, 1'b1, 2'd2, 1'b0, 1'b0, e, o);
        vectors++;
        if (o !== 1'b1 || Out3 !== 32'hA || Valid3 !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_first: got ir=%b out3=%h v3=%b expected ir=1 out3=a v3=1", o, Out3, Valid3);
        end
        step(32'hB, 1'b1, 2'd2, 1'b0, 1'b0, e, o);
        vectors++;
        if (o !== 1'b0 || Out3 !== 32'hA || Valid3 !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_stall: got ir=%b out3=%h v3=%b expected ir=0 out3=a v3=1", o, Out3, Valid3);
        end
        step(32'h77, 1'b1, 2'd0, 1'b0, 1'b0, e, o);
        vectors++;
        if (o !== 1'b1 || Out1 !== 32'h77 || Out3 !== 32'hA) begin
            miscompares++;
            $display("FAIL bp_other: got ir=%b out1=%h out3=%h expected ir=1 out1=77 out3=a", o, Out1, Out3);
        end
        rdy = 4'b1111;
        step(32'hB, 1'b1, 2'd2, 1'b0, 1'b0, e, o);
        vectors++;
        if (o !== 1'b1 || Out3 !== 32'hB || Valid3 !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_refill: got ir=%b out3=%h v3=%b expected ir=1 out3=b v3=1", o, Out3, Valid3);
        end
        step(32'h0, 1'b0, 2'd0, 1'b0, 1'b0, e, o);
        vectors++;
        if (Valid3 !== 1'b0 || Out3 !== 32'hB) begin
            miscompares++;
            $display("FAIL bp_drain: got v3=%b out3=%h expected v3=0 out3=b", Valid3, Out3);
        end
    endtask

    task automatic test_midframe();
        logic e, o;
        do_reset();
        rdy = 4'b1111;
        step(32'h1, 1'b1, 2'd0, 1'b1, 1'b1, e, o);
        step(32'h2, 1'b1, 2'd0, 1'b1, 1'b0, e, o);
        vectors++;
        if (Slot !== 2'd2) begin
            miscompares++;
            $display("FAIL mid_pre_slot: got %0d expected 2", Slot);
        end
        step(32'h55, 1'b1, 2'd3, 1'b1, 1'b1, e, o);
        vectors++;
        if (Out1 !== 32'h55 || Slot !== 2'd1 || Out3 !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_frame: got out1=%h slot=%0d out3=%h expected out1=55 slot=1 out3=0", Out1, Slot, Out3);
        end
    endtask

    task automatic test_mode_switch();
        logic e, o;
        do_reset();
        rdy = 4'b1111;
        for (int i = 0; i < 3; i++) step(32'(20 + i), 1'b1, 2'd0, 1'b1, (i == 0), e, o);
        step(32'd7, 1'b1, 2'd1, 1'b0, 1'b1, e, o);
        vectors++;
        if (Out2 !== 32'd7 || Valid2 !== 1'b1 || Slot !== 2'd3) begin
            miscompares++;
            $display("FAIL mode_sel: got out2=%h v2=%b slot=%0d expected out2=7 v2=1 slot=3", Out2, Valid2, Slot);
        end
        step(32'h99, 1'b1, 2'd0, 1'b1, 1'b0, e, o);
        vectors++;
        if (Out4 !== 32'h99 || Valid4 !== 1'b1 || Slot !== 2'd0 || Out1 !== 32'd20) begin
            miscompares++;
            $display("FAIL mode_back: got out4=%h v4=%b slot=%0d out1=%h expected out4=99 v4=1 slot=0 out1=14",
                     Out4, Valid4, Slot, Out1);
        end
    endtask

    task automatic test_async_reset();
        logic e, o;
        do_reset();
        rdy = 4'b0000;
        for (int i = 0; i < 4; i++) step(32'(100 + i), 1'b1, 2'(i), 1'b0, 1'b0, e, o);
        step(32'h1, 1'b1, 2'd0, 1'b1, 1'b1, e, o);
        #2;
        Rst = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (dout[c] !== 32'd0 || dval[c] !== 1'b0) begin
                miscompares++;
                $display("FAIL areset_ch%0d: got out=%h valid=%b expected out=0 valid=0", c, dout[c], dval[c]);
            end
        end
        vectors++;
        if (Slot !== 2'd0 || InReady !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_slot: got slot=%0d ir=%b expected slot=0 ir=1", Slot, InReady);
        end
        #1;
        Rst = 1'b0;
        model_clear();
        @(negedge Clk);
        rdy = 4'b1111;
        step(32'd9, 1'b1, 2'd0, 1'b0, 1'b0, e, o);
        vectors++;
        if (o !== 1'b1 || Out1 !== 32'd9 || Valid1 !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_after: got ir=%b out1=%h v1=%b expected ir=1 out1=9 v1=1", o, Out1, Valid1);
        end
    endtask

    task automatic test_random();
        logic e, o;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rdy = 4'($urandom);
            step($urandom, 1'($urandom_range(0, 3) != 0), 2'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 5) == 0), e, o);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL rand_inready_%0d: got %b expected %b", n, o, e);
            end
            for (int c = 0; c < 4; c++) begin
                vectors++;
                if (dout[c] !== m_out[c] || dval[c] !== m_val[c]) begin
                    miscompares++;
                    $display("FAIL rand_ch%0d_%0d: got out=%h valid=%b expected out=%h valid=%b",
                             c, n, dout[c], dval[c], m_out[c], m_val[c]);
                end
            end
            vectors++;
            if (Slot !== 2'(m_slot)) begin
                miscompares++;
                $display("FAIL rand_slot_%0d: got %0d expected %0d", n, Slot, m_slot);
            end
        end
    endtask

    initial begin
        Rst = 1'b1; In = '0; InValid = 1'b0; Sel = '0; Mode = 1'b0; FrameStart = 1'b0; rdy = 4'b1111;
        model_clear();
        test_reset();
        test_select();
        test_tdm_wrap();
        test_backpressure();
        test_midframe();
        test_mode_switch();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demultiplexor_tdm.md
# demultiplexor_tdm

Four-way, 32-bit registered demultiplexor: the receive-side counterpart to the four-input `multiplexor`. It takes one word stream and routes each accepted word to one of four output channels. The channel is chosen either by an explicit 2-bit select or by an internal time-division slot counter that advances on every accepted word. Each channel has a one-entry holding register with a valid/ready handshake, so a stalled consumer back-pressures only the words addressed to it.

## Interface
Parameters:
- `WIDTH`, 32, data width of the input and of each output channel.

Ports:
- `Clk`  in  1  single clock; all state updates on its rising edge.
- `Rst`  in  1  reset, asynchronous and active-high.
- `In`  in  WIDTH  input word.
- `InValid`  in  1  `In` holds a word.
- `InReady`  out  1  the block accepts `In` this cycle.
- `Sel`  in  2  target channel when `Mode`=0: 0→ch1, 1→ch2, 2→ch3, 3→ch4.
- `Mode`  in  1  0 = explicit select; 1 = TDM slot counter.
- `FrameStart`  in  1  `Mode`=1 only: the current word is slot 0.
- `Out1`..`Out4`  out  WIDTH  channel data registers.
- `Valid1`..`Valid4`  out  1  channel register holds an unconsumed word.
- `Ready1`..`Ready4`  in  1  consumer accepts the channel word this cycle.
- `Slot`  out  2  current TDM slot counter value.

## Operation
- Target channel `t`:
  - `Mode`=0: `t = Sel`.
  - `Mode`=1 and `FrameStart`=1: `t = 0`.
  - `Mode`=1 and `FrameStart`=0: `t = Slot`.
- `InReady = !Valid[t] || Ready[t]`. This is a combinational path from `ReadyN` and `Sel`/`Mode`/`FrameStart` to `InReady`; it is intended.
- Input accept: `InValid && InReady`. On accept, `Out[t] <= In` and `Valid[t] <= 1`.
- Channel consume: `ValidN && ReadyN` clears `ValidN`, unless the same channel is refilled in the same cycle, in which case `ValidN` stays 1 and the data is the new word.
- `OutN` holds its last value after consumption and is never cleared except by reset.
- Slot counter:
  - On accept with `Mode`=1: `Slot <= t + 1` modulo 4, so 3 wraps to 0.
  - `Mode`=0 or no accept: `Slot` holds.
- `FrameStart` without an accept has no effect.
- `FrameStart` is ignored when `Mode`=0.
- Switching `Mode` does not alter `Slot` or any channel contents.
- Reset (asynchronous, any time, including mid-transfer): all `OutN`=0, all `ValidN`=0, `Slot`=0. `InReady` then evaluates to 1.
- `Sel` and `In` are ignored when `InValid`=0.

## Timing
- Latency: a word accepted at edge k is visible on `OutN` with `ValidN`=1 after edge k, i.e. in cycle k+1.
- Throughput: one word per cycle into any channel whose consumer holds `ReadyN`=1, including back-to-back words into the same channel.
- A full channel whose `ReadyN`=0 forces `InReady`=0 only while it is the target. Words for other channels flow freely.
- In TDM mode, a stalled slot stalls the whole stream, because slot order is fixed.
- Reset removal: the first accept is possible on the first edge after `Rst` falls.

## Structure
- Shared package `demux_pkg`:
  - `NCH`=4.
  - Channel index typedef (2 bits).
  - Constants `MODE_SEL`=0 and `MODE_TDM`=1.
  - Default `WIDTH`=32.
- Sub-module `demux_chan_reg`: one-entry holding register with load/consume/valid logic, instantiated four times.
- Top level contains: target decode, `InReady` mux, slot counter.

## Test plan
- Explicit select, all consumers ready: `In`=1,2,3,4 with `Sel`=0,1,2,3 on consecutive cycles → `Out1`..`Out4`=1,2,3,4, each `ValidN` pulsing for one cycle, one cycle after its word.
- TDM wrap: `Mode`=1, `FrameStart` on word 10, then words 11,12,13,14 → `Out1`=10, `Out2`=11, `Out3`=12, `Out4`=13, then `Out1`=14. `Slot` reads 0,1,2,3,0,1.
- Back-pressure: `Ready3`=0, `Mode`=0, `Sel`=2 with `In`=0xA then 0xB → 0xA is held in `Out3`, `InReady`=0 for 0xB. A word with `Sel`=0 is still accepted. Raising `Ready3` lets 0xB load on the same edge 0xA is consumed, and `Valid3` stays 1.
- Mid-frame `FrameStart`: after 2 TDM words (`Slot`=2), `FrameStart` with `In`=0x55 → `Out1`=0x55 and `Slot`=1.
- Mode switch: TDM until `Slot`=3, then `Mode`=0 with `Sel`=1 and `In`=7 → `Out2`=7 and `Slot` stays 3. Return to TDM → next word goes to ch4.
- Reset mid-operation: assert `Rst` asynchronously between edges while channels hold data → all `OutN`/`ValidN`/`Slot` read 0 immediately. After release, `Sel`=0 with `In`=9 → `Out1`=9 one cycle later.
